// File: rtl/nand_target_emu.sv
// Behavioural NAND flash target: oversamples the asynchronous bus on sys_clk, decodes
// command/address/data cycles and serves a small page memory with ready/busy timing.
module nand_target_emu #(
   parameter int unsigned PAGE_BYTES  = 64,
   parameter int unsigned NUM_PAGES   = 32,
   parameter int unsigned BLOCK_PAGES = 8,
   parameter int unsigned T_READ      = 40,
   parameter int unsigned T_PROG      = 200,
   parameter int unsigned T_ERASE     = 800,
   parameter logic [39:0] ID_WORD     = 40'h2C_DA_90_95_06
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       ce,
   input  logic       cle,
   input  logic       ale,
   input  logic       we,
   input  logic       re,
   input  logic       wp,
   input  logic [7:0] dq_in,
   output logic [7:0] dq_out,
   output logic       dq_oe,
   output logic       r_b
);
   localparam int unsigned CW        = $clog2(PAGE_BYTES);
   localparam int unsigned RW        = $clog2(NUM_PAGES);
   localparam int unsigned BW        = $clog2(BLOCK_PAGES);
   localparam int unsigned EW        = CW + BW;
   localparam int unsigned MEM_BYTES = PAGE_BYTES * NUM_PAGES;
   localparam int unsigned BLK_BYTES = PAGE_BYTES * BLOCK_PAGES;
   localparam int unsigned T_PR_MAX  = (T_PROG > T_READ) ? T_PROG : T_READ;
   localparam int unsigned T_MAX0    = (T_ERASE > T_PR_MAX) ? T_ERASE : T_PR_MAX;
   localparam int unsigned T_MAX     = (T_MAX0 > 8) ? T_MAX0 : 8;
   localparam int unsigned TW        = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {StIdle, StAddr, StDin, StBusy, StDout, StIdout, StStout} state_e;
   typedef enum logic [1:0] {OpRead, OpProg, OpErase, OpId} op_e;
   typedef enum logic [1:0] {KNone, KRead, KProg, KErase} kind_e;

   // sync vectors are {wp, re, we, ale, cle, ce}; prev_q holds {re, we, ce}
   logic [5:0] sync1_q, sync2_q;
   logic [2:0] prev_q;
   logic ce_s, cle_s, ale_s, we_s, re_s, wp_s;

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   kind_e           kind_q, kind_d;
   logic [2:0]      addr_cnt_q, addr_cnt_d;
   logic [2:0]      id_idx_q, id_idx_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic            fail_q, fail_d;
   logic [TW-1:0]   busy_cnt_q, busy_cnt_d;
   logic [7:0]      dq_out_q, dq_out_d;

   logic [7:0]      mem_q  [MEM_BYTES];
   logic [7:0]      pbuf_q [PAGE_BYTES];
   logic            buf_fill, buf_we, mem_we;
   logic [CW+RW-1:0] mem_waddr;
   logic [7:0]      mem_wdata;

   logic            act, ce_rise, we_rise, re_fall, re_rise;
   logic            is_cmd, is_addr, is_data, busy, rd_state;
   logic [2:0]      addr_need, row_first, ri;
   logic [CW-1:0]   prog_idx;
   logic [EW-1:0]   erase_idx;
   logic [7:0]      status, rd_byte;

   assign ce_s  = sync2_q[0];
   assign cle_s = sync2_q[1];
   assign ale_s = sync2_q[2];
   assign we_s  = sync2_q[3];
   assign re_s  = sync2_q[4];
   assign wp_s  = sync2_q[5];

   assign act     = ~ce_s;
   assign ce_rise = ce_s & ~prev_q[0];
   assign we_rise = act & we_s & ~prev_q[1];
   assign re_fall = act & ~re_s & prev_q[2];
   assign re_rise = act & re_s & ~prev_q[2];
   assign is_cmd  = we_rise & cle_s & ~ale_s;
   assign is_addr = we_rise & ale_s & ~cle_s;
   assign is_data = we_rise & ~cle_s & ~ale_s;

   assign busy      = (busy_cnt_q != '0);
   assign rd_state  = state_q inside {StDout, StIdout, StStout};
   assign addr_need = (op_q == OpId) ? 3'd1 : (op_q == OpErase) ? 3'd3 : 3'd5;
   assign row_first = (op_q == OpErase) ? 3'd0 : 3'd2;
   assign ri        = addr_cnt_q - row_first;
   // Commits run in the final cycles of the busy window so an early 0xFF leaves memory intact
   assign prog_idx  = CW'(TW'(PAGE_BYTES) - busy_cnt_q);
   assign erase_idx = EW'(TW'(BLK_BYTES) - busy_cnt_q);
   assign status    = {~wp_s, ~busy, ~busy, 4'b0000, fail_q};

   always_comb begin
      case (state_q)
         StDout:  rd_byte = mem_q[{row_q, col_q}];
         StIdout: rd_byte = 8'(ID_WORD >> {3'd4 - id_idx_q, 3'b000});
         default: rd_byte = status;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 6'b111001;
         sync2_q <= 6'b111001;
         prev_q  <= 3'b111;
      end else begin
         sync1_q <= {wp, re, we, ale, cle, ce};
         sync2_q <= sync1_q;
         prev_q  <= {sync2_q[4], sync2_q[3], sync2_q[0]};
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      kind_d     = kind_q;
      addr_cnt_d = addr_cnt_q;
      id_idx_d   = id_idx_q;
      col_d      = col_q;
      row_d      = row_q;
      fail_d     = fail_q;
      busy_cnt_d = busy_cnt_q;
      dq_out_d   = dq_out_q;
      buf_fill   = 1'b0;
      buf_we     = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;

      if (busy) begin
         busy_cnt_d = busy_cnt_q - TW'(1);
         if (kind_q == KProg && busy_cnt_q <= TW'(PAGE_BYTES)) begin
            mem_we    = 1'b1;
            mem_waddr = {row_q, prog_idx};
            mem_wdata = mem_q[{row_q, prog_idx}] & pbuf_q[prog_idx];
         end else if (kind_q == KErase && busy_cnt_q <= TW'(BLK_BYTES)) begin
            mem_we    = 1'b1;
            mem_waddr = {row_q[RW-1:BW], erase_idx};
            mem_wdata = 8'hFF;
         end
         if (busy_cnt_q == TW'(1)) begin
            kind_d = KNone;
            if (state_q == StBusy) state_d = (kind_q == KRead) ? StDout : StIdle;
         end
      end

      if (ce_rise) state_d = StIdle;

      if (is_cmd) begin
         if (dq_in == 8'hFF) begin
            state_d    = StBusy;
            busy_cnt_d = TW'(8);
            kind_d     = KNone;
            fail_d     = 1'b0;
         end else if (dq_in == 8'h70) begin
            state_d = StStout;
         end else if (!busy) begin
            case (dq_in)
               8'h90, 8'h00, 8'h80, 8'h60: begin
                  state_d    = StAddr;
                  addr_cnt_d = 3'd0;
                  op_d       = (dq_in == 8'h90) ? OpId : (dq_in == 8'h00) ? OpRead :
                               (dq_in == 8'h80) ? OpProg : OpErase;
                  if (dq_in == 8'h80 || dq_in == 8'h60) fail_d = 1'b0;
                  if (dq_in == 8'h80) buf_fill = 1'b1;
               end
               8'h30: begin
                  state_d = StIdle;
                  if (state_q == StAddr && op_q == OpRead && addr_cnt_q == 3'd5) begin
                     state_d    = StBusy;
                     busy_cnt_d = TW'(T_READ);
                     kind_d     = KRead;
                  end
               end
               8'h10, 8'hD0: begin
                  state_d = StIdle;
                  if ((dq_in == 8'h10 && state_q == StDin) ||
                      (dq_in == 8'hD0 && state_q == StAddr && op_q == OpErase &&
                       addr_cnt_q == 3'd3)) begin
                     state_d    = StBusy;
                     busy_cnt_d = (dq_in == 8'h10) ? TW'(T_PROG) : TW'(T_ERASE);
                     if (!wp_s) begin
                        fail_d = 1'b1;
                        kind_d = KNone;
                     end else begin
                        kind_d = (dq_in == 8'h10) ? KProg : KErase;
                     end
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end else if (is_addr && !busy) begin
         if (state_q == StAddr) begin
            if (addr_cnt_q >= addr_need) begin
               state_d = StIdle;
            end else begin
               addr_cnt_d = addr_cnt_q + 3'd1;
               if (op_q == OpId) begin
                  state_d  = StIdout;
                  id_idx_d = 3'd0;
               end else if (addr_cnt_q < row_first) begin
                  col_d = (addr_cnt_q == 3'd0) ? CW'(dq_in) : (col_q | CW'({dq_in, 8'h00}));
               end else begin
                  row_d = (ri == 3'd0) ? RW'(dq_in) : (row_q | RW'(24'(dq_in) << {ri, 3'b000}));
               end
               if (op_q == OpProg && addr_cnt_q == 3'd4) state_d = StDin;
            end
         end else if (state_q == StDin) begin
            state_d = StIdle;
         end
      end else if (is_data && !busy) begin
         if (state_q == StDin) begin
            buf_we = 1'b1;
            col_d  = col_q + CW'(1);
         end else if (state_q == StAddr) begin
            state_d = StIdle;
         end
      end

      if (rd_state) begin
         if (re_fall) dq_out_d = rd_byte;
         if (re_rise) begin
            if (state_q == StDout) col_d = col_q + CW'(1);
            if (state_q == StIdout) id_idx_d = (id_idx_q == 3'd4) ? 3'd0 : id_idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         op_q       <= OpRead;
         kind_q     <= KNone;
         addr_cnt_q <= '0;
         id_idx_q   <= '0;
         col_q      <= '0;
         row_q      <= '0;
         fail_q     <= 1'b0;
         busy_cnt_q <= '0;
         dq_out_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         kind_q     <= kind_d;
         addr_cnt_q <= addr_cnt_d;
         id_idx_q   <= id_idx_d;
         col_q      <= col_d;
         row_q      <= row_d;
         fail_q     <= fail_d;
         busy_cnt_q <= busy_cnt_d;
         dq_out_q   <= dq_out_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (buf_fill) begin
         for (int i = 0; i < int'(PAGE_BYTES); i++) pbuf_q[i] <= 8'hFF;
      end else if (buf_we) begin
         pbuf_q[col_q] <= dq_in;
      end
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign dq_out = dq_out_q;
   assign dq_oe  = rd_state & ~ce_s & ~re_s;
   assign r_b    = ~busy;

endmodule

// File: tb/tb_nand_target_emu.sv
// Directed bench for nand_target_emu: read bytes and busy widths are queued as expectations
// and checked by independent monitors on dq_oe falling and r_b rising.
module tb_nand_target_emu;
   localparam int T_READ  = 40;
   localparam int T_PROG  = 200;
   localparam int T_ERASE = 800;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       ce = 1'b1, cle = 1'b0, ale = 1'b0, we = 1'b1, re = 1'b1, wp = 1'b1;
   logic [7:0] dq_in = 8'h00;
   logic [7:0] dq_out;
   logic       dq_oe, r_b;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         busy_q[$];
   int         rd_num = 0;
   int         low_cnt = 0;
   int         bexp;
   logic [7:0] dexp;
   logic       oe_prev = 1'b0;

   always #5 sys_clk = ~sys_clk;

   nand_target_emu dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .ce        (ce),
      .cle       (cle),
      .ale       (ale),
      .we        (we),
      .re        (re),
      .wp        (wp),
      .dq_in     (dq_in),
      .dq_out    (dq_out),
      .dq_oe     (dq_oe),
      .r_b       (r_b)
   );

   // Read-data monitor: a byte is complete when dq_oe drops
   always @(negedge sys_clk) begin
      if (oe_prev && !dq_oe) begin
         rd_num++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd#%0d unexpected: dq_out=%h, no byte expected", rd_num, dq_out);
         end else begin
            dexp = exp_q.pop_front();
            if (dq_out !== dexp) begin
               n_err++;
               $display("FAIL rd#%0d: dq_out=%h, expected %h", rd_num, dq_out, dexp);
            end
         end
      end
      oe_prev = dq_oe;
   end

   // Busy-width monitor; an expectation of 0 means the width is checked elsewhere
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (r_b === 1'b0) begin
            low_cnt++;
         end else if (low_cnt != 0) begin
            if (busy_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL busy_unexpected: r_b low %0d cycles, none expected", low_cnt);
            end else begin
               bexp = busy_q.pop_front();
               if (bexp != 0) begin
                  n_vec++;
                  if (low_cnt != bexp) begin
                     n_err++;
                     $display("FAIL busy_width: r_b low %0d cycles, expected %0d", low_cnt, bexp);
                  end
               end
            end
            low_cnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bus(input logic c, input logic a, input logic [7:0] b);
      ce = 1'b0; cle = c; ale = a; dq_in = b;
      #20 we = 1'b0;
      #40 we = 1'b1;
      #40 cle = 1'b0; ale = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b); bus(1'b1, 1'b0, b); endtask
   task automatic adr(input logic [7:0] b); bus(1'b0, 1'b1, b); endtask
   task automatic din(input logic [7:0] b); bus(1'b0, 1'b0, b); endtask

   task automatic addr5(input logic [7:0] col, input logic [7:0] row);
      adr(col); adr(8'h00); adr(row); adr(8'h00); adr(8'h00);
   endtask

   task automatic rd(input logic [7:0] e);
      exp_q.push_back(e);
      re = 1'b0;
      #40 re = 1'b1;
      #40;
   endtask

   task automatic wait_ready(input int lim);
      int k = 0;
      while (r_b !== 1'b1 && k < lim) begin
         @(negedge sys_clk);
         k++;
      end
      if (r_b !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_ready: r_b=%b after %0d cycles", r_b, k);
      end
      #1;
   endtask

   task automatic read_page(input logic [7:0] col, input logic [7:0] row);
      cmd(8'h00); addr5(col, row);
      busy_q.push_back(T_READ);
      cmd(8'h30);
      wait_ready(T_READ + 50);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      #21;
      chk("rst_dq_out", 16'(dq_out), 16'h00);
      chk("rst_dq_oe", 16'(dq_oe), 16'h0);
      chk("rst_r_b", 16'(r_b), 16'h1);
      #10 sys_rst_n = 1'b1;
      #40;

      // Read ID with wrap, then ce rising mid-pulse
      cmd(8'h90); adr(8'h00);
      rd(8'h2C); rd(8'hDA); rd(8'h90); rd(8'h95); rd(8'h06); rd(8'h2C);
      exp_q.push_back(8'hDA);
      re = 1'b0;
      #40 ce = 1'b1;
      #40 chk("ce_rise_oe", 16'(dq_oe), 16'h0);
      re = 1'b1;
      #40 ce = 1'b0;
      #40 re = 1'b0;
      #40 chk("idle_no_oe", 16'(dq_oe), 16'h0);
      re = 1'b1;
      #40 chk("id_r_b", 16'(r_b), 16'h1);

      // Unexpected data cycle in ADDR, then a stray 0x30: no busy
      cmd(8'h00); adr(8'h00); din(8'h11); cmd(8'h30);
      #100 chk("bad_seq_r_b", 16'(r_b), 16'h1);

      // Erase block 0 and read page 0 back as all FF
      cmd(8'h60); adr(8'h00); adr(8'h00); adr(8'h00);
      busy_q.push_back(T_ERASE);
      cmd(8'hD0);
      wait_ready(T_ERASE + 50);
      read_page(8'h00, 8'h00);
      for (int i = 0; i < 64; i++) rd(8'hFF);

      // Program page 3 with 0x00..0x3F and read back with column wrap
      cmd(8'h80); addr5(8'h00, 8'h03);
      for (int i = 0; i < 64; i++) din(8'(i));
      busy_q.push_back(T_PROG);
      cmd(8'h10);
      wait_ready(T_PROG + 50);
      read_page(8'h00, 8'h03);
      for (int i = 0; i < 64; i++) rd(8'(i));
      rd(8'h00);

      // AND-programming 0xF0 over 0x3C at column 0x3C
      cmd(8'h80); addr5(8'h3C, 8'h03);
      din(8'hF0);
      busy_q.push_back(T_PROG);
      cmd(8'h10);
      wait_ready(T_PROG + 50);
      read_page(8'h3C, 8'h03);
      rd(8'h30); rd(8'h3D); rd(8'h3E); rd(8'h3F); rd(8'h00); rd(8'h01);

      // Write-protected program of page 5 fails and leaves the page erased
      wp = 1'b0;
      #40;
      cmd(8'h80); addr5(8'h00, 8'h05);
      din(8'hAA); din(8'h55);
      busy_q.push_back(T_PROG);
      cmd(8'h10);
      wait_ready(T_PROG + 50);
      cmd(8'h70);
      rd(8'hE1); rd(8'hE1);
      wp = 1'b1;
      #40;
      rd(8'h61);
      read_page(8'h00, 8'h05);
      rd(8'hFF); rd(8'hFF); rd(8'hFF); rd(8'hFF);

      // 0xFF 100 cycles into an erase: busy ends 3 sync + 8 cycles after the we edge
      cmd(8'h60); adr(8'h00); adr(8'h00); adr(8'h00);
      busy_q.push_back(0);
      cmd(8'hD0);
      repeat (100) @(negedge sys_clk);
      #1;
      ce = 1'b0; cle = 1'b1; ale = 1'b0; dq_in = 8'hFF;
      #20 we = 1'b0;
      #40 we = 1'b1;
      k = 0;
      while (r_b !== 1'b1 && k < 50) begin
         @(negedge sys_clk);
         k++;
      end
      chk("reset_busy_len", 16'(k), 16'd11);
      #1 cle = 1'b0;
      #40;
      read_page(8'h00, 8'h03);
      rd(8'h00); rd(8'h01); rd(8'h02);
      cmd(8'h70);
      rd(8'h60);

      #200;
      chk("sb_drain", 16'(exp_q.size()), 16'd0);
      chk("busy_drain", 16'(busy_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
